// File: rtl/tpu_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tpu_cmd_pkg : 64-bit command format shared by cmd_issuer/control_unit |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package tpu_cmd_pkg;

  localparam int CMD_ADDR_W = 10;
  localparam int CMD_DIM_W  = 8;

  localparam int D_LSB = 54;
  localparam int C_LSB = 44;
  localparam int B_LSB = 34;
  localparam int A_LSB = 24;
  localparam int N_LSB = 16;
  localparam int K_LSB = 8;
  localparam int M_LSB = 0;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] d_addr;
    logic [CMD_ADDR_W-1:0] c_addr;
    logic [CMD_ADDR_W-1:0] b_addr;
    logic [CMD_ADDR_W-1:0] a_addr;
    logic [CMD_DIM_W-1:0]  n;
    logic [CMD_DIM_W-1:0]  k;
    logic [CMD_DIM_W-1:0]  m;
  } cmd_desc_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_ISSUE = 2'd2
  } issue_state_t;

  function automatic logic [63:0] pack_cmd(input cmd_desc_t desc);
    logic [63:0] cmd;
    cmd = '0;
    cmd[D_LSB +: CMD_ADDR_W] = desc.d_addr;
    cmd[C_LSB +: CMD_ADDR_W] = desc.c_addr;
    cmd[B_LSB +: CMD_ADDR_W] = desc.b_addr;
    cmd[A_LSB +: CMD_ADDR_W] = desc.a_addr;
    cmd[N_LSB +: CMD_DIM_W]  = desc.n;
    cmd[K_LSB +: CMD_DIM_W]  = desc.k;
    cmd[M_LSB +: CMD_DIM_W]  = desc.m;
    return cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, registered full/empty, pow2 depth >= 2 |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/cmd_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmd_issuer : descriptor FIFO + credit-limited 64-bit command issuer   |
// | Optional watchdog: CMD_ISSUER_TIMEOUT_EN            Rev 1.0           |
// +----------------------------------------------------------------------+
module cmd_issuer
  import tpu_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH           = 10,
  parameter int DIM_WIDTH            = 8,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DESC_DEPTH           = 4,
  parameter int MAX_OUTSTANDING      = 4
`ifdef CMD_ISSUER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES     = 4096
`endif
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 desc_valid,
  output logic                                 desc_ready,
  input  logic [ADDR_WIDTH-1:0]                desc_d_addr,
  input  logic [ADDR_WIDTH-1:0]                desc_c_addr,
  input  logic [ADDR_WIDTH-1:0]                desc_b_addr,
  input  logic [ADDR_WIDTH-1:0]                desc_a_addr,
  input  logic [DIM_WIDTH-1:0]                 desc_m,
  input  logic [DIM_WIDTH-1:0]                 desc_k,
  input  logic [DIM_WIDTH-1:0]                 desc_n,
  output logic                                 cmd_valid,
  output logic [63:0]                          cmd_data,
  input  logic                                 cmd_ready,
  input  logic                                 done_irq,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic [15:0]                          issued_count,
  output logic [15:0]                          retired_count,
  output logic                                 err_dim,
  output logic                                 err_spurious,
  output logic                                 idle
`ifdef CMD_ISSUER_TIMEOUT_EN
  , output logic                               err_timeout
`endif
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0]        OUT_MAX = MAX_OUTSTANDING[OW-1:0];
  localparam logic [DIM_WIDTH-1:0] DIM_MAX = SYSTOLIC_ARRAY_WIDTH[DIM_WIDTH-1:0];

  issue_state_t state, state_nxt;
  cmd_desc_t    in_desc;
  cmd_desc_t    head_desc;
  logic [63:0]  fifo_rd;
  logic         fifo_full;
  logic         fifo_empty;
  logic         intake;
  logic         legal;
  logic         pop;
  logic         hs;
  logic         retire;
  logic         has_credit;

  function automatic logic dim_ok(input logic [DIM_WIDTH-1:0] v);
    return (v != '0) && (v <= DIM_MAX);
  endfunction

  always_comb begin
    in_desc        = '0;
    in_desc.d_addr = desc_d_addr;
    in_desc.c_addr = desc_c_addr;
    in_desc.b_addr = desc_b_addr;
    in_desc.a_addr = desc_a_addr;
    in_desc.m      = desc_m;
    in_desc.k      = desc_k;
    in_desc.n      = desc_n;
  end

  assign desc_ready = !fifo_full;
  assign intake     = desc_valid && desc_ready;
  assign legal      = dim_ok(desc_m) && dim_ok(desc_k) && dim_ok(desc_n);
  assign head_desc  = fifo_rd;
  assign has_credit = (outstanding < OUT_MAX);
  assign hs         = cmd_valid && cmd_ready;
  assign retire     = done_irq && (outstanding != '0);
  assign idle       = fifo_empty && (state == ST_IDLE) && (outstanding == '0);

  sync_fifo #(
    .WIDTH (64),
    .DEPTH (DESC_DEPTH)
  ) u_desc_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (intake && legal),
    .wr_data (in_desc),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef CMD_ISSUER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else if (done_irq || (outstanding == '0)) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) err_timeout <= 1'b1;
    end
  end

  assign cmd_valid = (state == ST_ISSUE) && !err_timeout;
`else
  assign cmd_valid = (state == ST_ISSUE);
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          if (has_credit) begin
            pop       = 1'b1;
            state_nxt = ST_ISSUE;
          end else begin
            state_nxt = ST_STALL;
          end
        end
      end
      ST_STALL: if (has_credit) state_nxt = ST_IDLE;
      ST_ISSUE: if (cmd_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
`ifdef CMD_ISSUER_TIMEOUT_EN
    // A timed-out unit is parked until the host resets it.
    if (err_timeout) begin
      pop       = 1'b0;
      state_nxt = ST_STALL;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      cmd_data      <= '0;
      outstanding   <= '0;
      issued_count  <= '0;
      retired_count <= '0;
      err_dim       <= 1'b0;
      err_spurious  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (pop) cmd_data <= pack_cmd(head_desc);
      if (hs && !retire)      outstanding <= outstanding + 1'b1;
      else if (!hs && retire) outstanding <= outstanding - 1'b1;
      if (hs)     issued_count  <= issued_count + 16'd1;
      if (retire) retired_count <= retired_count + 16'd1;
      if (intake && !legal) err_dim <= 1'b1;
      if (done_irq && (outstanding == '0)) err_spurious <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmd_issuer.sv
`default_nettype none
// tb_cmd_issuer : vector table, hand sequences and random traffic against a
// transaction-level model (expected command queue + credit arithmetic).
module tb_cmd_issuer;

  localparam int MAXO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [9:0]  desc_d_addr = '0, desc_c_addr = '0, desc_b_addr = '0, desc_a_addr = '0;
  logic [7:0]  desc_m = '0, desc_k = '0, desc_n = '0;
  logic        cmd_valid;
  logic [63:0] cmd_data;
  logic        cmd_ready = 1'b0;
  logic        done_irq = 1'b0;
  logic [2:0]  outstanding;
  logic [15:0] issued_count, retired_count;
  logic        err_dim, err_spurious, idle;

  always #5 clk = ~clk;

  cmd_issuer dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_d_addr(desc_d_addr), .desc_c_addr(desc_c_addr),
    .desc_b_addr(desc_b_addr), .desc_a_addr(desc_a_addr),
    .desc_m(desc_m), .desc_k(desc_k), .desc_n(desc_n),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .done_irq(done_irq), .outstanding(outstanding),
    .issued_count(issued_count), .retired_count(retired_count),
    .err_dim(err_dim), .err_spurious(err_spurious), .idle(idle)
  );

  typedef struct { logic [9:0] d, c, b, a; logic [7:0] m, k, n; } desc_t;
  typedef struct { desc_t in; bit legal; logic [63:0] cmd; } vec_t;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];
  int          m_out, m_iss, m_ret;
  bit          m_errdim, m_errsp;
  bit          last_acc, last_hs;
  logic [63:0] last_hs_data;

  function automatic bit ref_legal(input desc_t x);
    return (x.m >= 1 && x.m <= 16) && (x.k >= 1 && x.k <= 16) && (x.n >= 1 && x.n <= 16);
  endfunction

  function automatic logic [63:0] ref_pack(input desc_t x);
    return (64'(x.d) << 54) | (64'(x.c) << 44) | (64'(x.b) << 34) | (64'(x.a) << 24)
         | (64'(x.n) << 16) | (64'(x.k) << 8) | 64'(x.m);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; desc_valid = 1'b0; cmd_ready = 1'b0; done_irq = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    m_out = 0; m_iss = 0; m_ret = 0; m_errdim = 0; m_errsp = 0;
  endtask

  // One clock: drive inputs, advance the model on this cycle's events, then check.
  task automatic step(input bit dv, input desc_t x, input bit cr, input bit di);
    bit          hold;
    logic [63:0] held;
    desc_valid = dv;
    desc_d_addr = x.d; desc_c_addr = x.c; desc_b_addr = x.b; desc_a_addr = x.a;
    desc_m = x.m; desc_k = x.k; desc_n = x.n;
    cmd_ready = cr; done_irq = di;
    last_acc = dv && desc_ready;
    last_hs = cmd_valid && cr;
    last_hs_data = cmd_data;
    hold = cmd_valid && !cr;
    held = cmd_data;
    if (cmd_valid) chk("credit_limit", m_out < MAXO, 1);
    if (last_acc) begin
      if (ref_legal(x)) exp_q.push_back(ref_pack(x));
      else m_errdim = 1;
    end
    if (last_hs) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_cmd: got 0x%0h expected no command", cmd_data);
      end else begin
        chk("cmd_data_order", cmd_data, exp_q.pop_front());
      end
      m_iss++;
    end
    if (di) begin
      if (m_out == 0) m_errsp = 1;
      else begin m_ret++; m_out--; end
    end
    if (last_hs) m_out++;
    @(posedge clk); #1;
    chk("outstanding", outstanding, m_out);
    chk("issued_count", issued_count, m_iss[15:0]);
    chk("retired_count", retired_count, m_ret[15:0]);
    chk("err_dim", err_dim, m_errdim);
    chk("err_spurious", err_spurious, m_errsp);
    if (hold) begin
      chk("hold_valid", cmd_valid, 1);
      chk("hold_data", cmd_data, held);
    end
  endtask

  task automatic nop(input bit cr, input bit di);
    desc_t z;
    z = '{default: '0};
    step(0, z, cr, di);
  endtask

  task automatic push(input desc_t x, input bit cr);
    for (int i = 0; i < 50; i++) begin
      step(1, x, cr, 0);
      if (last_acc) break;
    end
    if (!last_acc) begin
      tests++; fails++;
      $display("FAIL push_timeout: desc_ready stuck at %0b, required 1", desc_ready);
    end
  endtask

  function automatic desc_t mk(input int d, c, b, a, m, k, n);
    desc_t x;
    x.d = 10'(d); x.c = 10'(c); x.b = 10'(b); x.a = 10'(a);
    x.m = 8'(m); x.k = 8'(k); x.n = 8'(n);
    return x;
  endfunction

  function automatic logic [7:0] rnd_dim();
    if ($urandom_range(0, 7) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(1, 16));
  endfunction

  vec_t vt[9];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{mk(300, 200, 100, 0, 16, 16, 16), 1, 64'h4B0C_8190_0010_1010};
    vt[1] = '{mk(1023, 1023, 1023, 1023, 16, 16, 16), 1, 64'hFFFF_FFFF_FF10_1010};
    vt[2] = '{mk(1, 0, 0, 0, 1, 1, 1), 1, 64'h0040_0000_0001_0101};
    vt[3] = '{mk(0, 0, 0, 1, 8, 8, 8), 1, 64'h0000_0000_0108_0808};
    vt[4] = '{mk(5, 5, 5, 5, 0, 5, 5), 0, 64'h0};
    vt[5] = '{mk(5, 5, 5, 5, 5, 17, 5), 0, 64'h0};
    vt[6] = '{mk(5, 5, 5, 5, 5, 5, 255), 0, 64'h0};
    vt[7] = '{mk(0, 0, 1, 0, 16, 1, 2), 1, 64'h0000_0004_0002_0110};
    vt[8] = '{mk(0, 1, 0, 0, 15, 14, 13), 1, 64'h0000_1000_000D_0E0F};

    // Reset state and first-command latency
    do_reset();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_data", cmd_data, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_issued", issued_count, 0);
    chk("rst_retired", retired_count, 0);
    chk("rst_err_dim", err_dim, 0);
    chk("rst_err_spurious", err_spurious, 0);
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_idle", idle, 1);
    push(vt[0].in, 1);
    chk("lat_t1_valid", cmd_valid, 0);
    nop(1, 0);
    chk("lat_t2_valid", cmd_valid, 1);
    chk("lat_t2_data", cmd_data, 64'h4B0C_8190_0010_1010);
    nop(1, 0);
    chk("t1_outstanding", outstanding, 1);
    chk("t1_issued", issued_count, 1);

    // Table-driven packing and validation
    for (int i = 0; i < 9; i++) begin
      logic [63:0] cap;
      cap = '0;
      do_reset();
      push(vt[i].in, 1);
      for (int j = 0; j < 6; j++) begin
        nop(1, 0);
        if (last_hs) cap = last_hs_data;
      end
      chk($sformatf("vec%0d_issued", i), issued_count, vt[i].legal ? 16'd1 : 16'd0);
      chk($sformatf("vec%0d_err_dim", i), err_dim, !vt[i].legal);
      if (vt[i].legal) chk($sformatf("vec%0d_cmd", i), cap, vt[i].cmd);
    end

    // Backpressure: held for 5 cycles, single handshake
    do_reset();
    push(vt[2].in, 0);
    nop(0, 0);
    for (int i = 0; i < 5; i++) begin
      nop(0, 0);
      chk("bp_valid", cmd_valid, 1);
      chk("bp_data", cmd_data, 64'h0040_0000_0001_0101);
    end
    nop(1, 0);
    chk("bp_issued", issued_count, 1);
    for (int i = 0; i < 3; i++) nop(1, 0);
    chk("bp_issued_once", issued_count, 1);
    chk("bp_outstanding", outstanding, 1);

    // Credit limit and stall release
    do_reset();
    for (int i = 0; i < 6; i++) push(mk(i, i + 1, i + 2, i + 3, 1 + i, 2, 3), 1);
    for (int i = 0; i < 12; i++) nop(1, 0);
    chk("credit_issued", issued_count, 4);
    chk("credit_outstanding", outstanding, 4);
    chk("credit_stall_valid", cmd_valid, 0);
    chk("credit_not_idle", idle, 0);
    nop(1, 1);
    for (int i = 0; i < 6; i++) nop(1, 0);
    chk("credit_issued5", issued_count, 5);
    chk("credit_outstanding4", outstanding, 4);
    chk("credit_retired", retired_count, 1);

    // Illegal dimensions dropped
    do_reset();
    push(mk(1, 1, 1, 1, 0, 4, 4), 1);
    push(mk(1, 1, 1, 1, 4, 17, 4), 1);
    push(mk(7, 6, 5, 4, 8, 8, 8), 1);
    for (int i = 0; i < 8; i++) nop(1, 0);
    chk("dim_err", err_dim, 1);
    chk("dim_issued", issued_count, 1);

    // Simultaneous handshake and done_irq, then spurious done
    do_reset();
    for (int i = 0; i < 3; i++) push(mk(i, 0, 0, 0, 2, 2, 2), 0);
    for (int i = 0; i < 40; i++) begin
      if (outstanding == 2 && cmd_valid) break;
      nop(outstanding < 2, 0);
    end
    chk("sim_setup_out2_valid", {outstanding, cmd_valid}, {3'd2, 1'b1});
    nop(1, 1);
    chk("sim_outstanding", outstanding, 2);
    chk("sim_issued", issued_count, 3);
    chk("sim_retired", retired_count, 1);
    nop(0, 1);
    nop(0, 1);
    chk("sim_drained", outstanding, 0);
    chk("sim_no_spurious", err_spurious, 0);
    nop(0, 1);
    chk("spurious_flag", err_spurious, 1);
    chk("spurious_retired", retired_count, 3);
    chk("spurious_outstanding", outstanding, 0);

    // Reset during ISSUE with 3 queued entries
    do_reset();
    for (int i = 0; i < 4; i++) push(mk(i, i, i, i, 3, 3, 3), 0);
    chk("mid_pre_valid", cmd_valid, 1);
    do_reset();
    chk("mid_valid", cmd_valid, 0);
    chk("mid_outstanding", outstanding, 0);
    chk("mid_idle", idle, 1);
    chk("mid_desc_ready", desc_ready, 1);
    for (int i = 0; i < 3; i++) nop(1, 0);
    chk("mid_no_issue", issued_count, 0);
    chk("mid_still_idle", idle, 1);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      desc_t x;
      x.d = 10'($urandom_range(0, 1023)); x.c = 10'($urandom_range(0, 1023));
      x.b = 10'($urandom_range(0, 1023)); x.a = 10'($urandom_range(0, 1023));
      x.m = rnd_dim(); x.k = rnd_dim(); x.n = rnd_dim();
      step(bit'($urandom_range(0, 1)), x, $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2);
    end
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && m_out == 0 && !cmd_valid) break;
      nop(1, m_out > 0);
    end
    chk("rand_drain_idle", idle, 1);
    chk("rand_drain_valid", cmd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
